// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier front end.
package booth_pkg;

    localparam int BOOTH_WIDTH   = 16;
    localparam int BOOTH_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_Q,
        WAIT,
        RESP
    } seq_state_e;

endpackage

// File: rtl/booth_operand_sequencer_if.sv
// Operand, result and multiplier-side signals of the Booth operand sequencer.
interface booth_operand_sequencer_if
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = $clog2(BOOTH_TIMEOUT + 1)
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   in_mcand;
    logic signed [WIDTH-1:0]   in_mplier;

    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] out_product;
    logic                      out_err;
    logic [CNT_W-1:0]          out_cycles;

    logic                      mul_start;
    logic [WIDTH-1:0]          mul_data;
    logic                      mul_done;
    logic [WIDTH-1:0]          mul_a;
    logic [WIDTH-1:0]          mul_q;

    // Environment side: operand producer, result consumer and multiplier.
    modport master (
        output in_valid, in_mcand, in_mplier, out_ready, mul_done, mul_a, mul_q,
        input  in_ready, out_valid, out_product, out_err, out_cycles, mul_start, mul_data
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_mcand, in_mplier, out_ready, mul_done, mul_a, mul_q,
        output in_ready, out_valid, out_product, out_err, out_cycles, mul_start, mul_data
    );
endinterface

// File: rtl/booth_seq_timer.sv
// Cycle counter for the WAIT state; flags the last permitted cycle before timeout.
module booth_seq_timer
    import booth_pkg::*;
#(
    parameter int TIMEOUT = BOOTH_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             expired_o
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/booth_operand_sequencer.sv
// Serialises an operand pair onto the Booth multiplier load bus and returns
// the captured {A,Q} product, or a timeout result if done never arrives.
module booth_operand_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH   = BOOTH_WIDTH,
    parameter int TIMEOUT = BOOTH_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    booth_operand_sequencer_if.slave    bus
);
    seq_state_e                state_q, state_d;
    logic signed [WIDTH-1:0]   mcand_q, mplier_q;
    logic signed [2*WIDTH-1:0] prod_q;
    logic                      err_q;
    logic [CNT_W-1:0]          cycles_q;

    logic                      accept;
    logic                      tmr_en;
    logic                      cap_done;
    logic                      cap_timeout;
    logic                      in_ready_c;
    logic                      mul_start_c;
    logic [WIDTH-1:0]          mul_data_c;
    logic [CNT_W-1:0]          wait_cnt;
    logic                      wait_expired;

    booth_seq_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .enable_i  (tmr_en),
        .count_o   (wait_cnt),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        tmr_en      = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        in_ready_c  = 1'b0;
        mul_start_c = 1'b0;
        mul_data_c  = '0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD_M;
                end
            end
            LOAD_M: begin
                mul_start_c = 1'b1;
                mul_data_c  = mcand_q;
                state_d     = LOAD_Q;
            end
            LOAD_Q: begin
                mul_start_c = 1'b1;
                mul_data_c  = mplier_q;
                state_d     = WAIT;
            end
            WAIT: begin
                tmr_en = 1'b1;
                // A done arriving on the final permitted cycle still counts as success.
                if (bus.mul_done) begin
                    cap_done = 1'b1;
                    state_d  = RESP;
                end else if (wait_expired) begin
                    cap_timeout = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prod_q   <= '0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q <= state_d;
            if (cap_done) begin
                prod_q   <= {bus.mul_a, bus.mul_q};
                err_q    <= 1'b0;
                cycles_q <= wait_cnt + CNT_W'(1);
            end else if (cap_timeout) begin
                prod_q   <= '0;
                err_q    <= 1'b1;
                cycles_q <= CNT_W'(TIMEOUT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mcand_q  <= bus.in_mcand;
            mplier_q <= bus.in_mplier;
        end
    end

    // in_ready is held low while reset is asserted, even though the state is already IDLE.
    assign bus.in_ready    = in_ready_c && !rst;
    assign bus.mul_start   = mul_start_c;
    assign bus.mul_data    = mul_data_c;
    assign bus.out_valid   = (state_q == RESP);
    assign bus.out_product = prod_q;
    assign bus.out_err     = err_q;
    assign bus.out_cycles  = cycles_q;
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Scoreboard bench for booth_operand_sequencer with a behavioural Booth multiplier model.
module tb_booth_operand_sequencer;
    import booth_pkg::*;

    localparam int W  = 16;
    localparam int TO = 64;
    localparam int CW = $clog2(TO + 1);

    typedef struct {
        logic [31:0]   prod;
        logic          err;
        logic [CW-1:0] cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_operand_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    booth_operand_sequencer #(
        .WIDTH   (W),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cyc = -1;

    res_t        exp_q[$];
    logic [15:0] ld_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    always @(posedge clk) cyc++;

    // Behavioural multiplier: takes M then Q off the load bus, pulses done after lat WAIT cycles.
    logic [15:0]        m_m, m_q;
    logic signed [31:0] m_p;
    bit                 got_m   = 0;
    bit                 active  = 0;
    bit                 done_en = 1;
    int                 wcnt    = 0;
    int                 lat     = 16;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mcand  = '0;
        bus.in_mplier = '0;
        bus.out_ready = 1'b1;
        bus.mul_done  = 1'b0;
        bus.mul_a     = '0;
        bus.mul_q     = '0;
    end

    always @(negedge clk) begin
        bus.mul_done = 1'b0;
        if (bus.mul_start) begin
            if (!got_m) begin
                m_m   = bus.mul_data;
                got_m = 1;
            end else begin
                m_q    = bus.mul_data;
                got_m  = 0;
                active = 1;
                wcnt   = 0;
            end
        end else if (active) begin
            wcnt++;
            if (wcnt == lat) begin
                active = 0;
                if (done_en) begin
                    m_p          = $signed(m_m) * $signed(m_q);
                    bus.mul_a    = m_p[31:16];
                    bus.mul_q    = m_p[15:0];
                    bus.mul_done = 1'b1;
                end
            end
        end
    end

    // Monitor: load-bus words and result handshakes are popped from the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mul_start) begin
                if (ld_q.size() == 0) begin
                    fail_now("unexpected_load", $sformatf("mul_start with data 0x%0h", bus.mul_data));
                end else begin
                    check("mul_data", {48'd0, bus.mul_data}, {48'd0, ld_q.pop_front()});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result", $sformatf("product 0x%0h err %0d", bus.out_product, bus.out_err));
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("out_product", {32'd0, bus.out_product}, {32'd0, e.prod});
                    check("out_err",     {63'd0, bus.out_err},     {63'd0, e.err});
                    check("out_cycles",  64'(bus.out_cycles),      64'(e.cyc));
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] m, input logic [15:0] q,
                            input logic [31:0] prod, input logic err, input int cy);
        res_t e;
        e.prod = prod;
        e.err  = err;
        e.cyc  = CW'(cy);
        exp_q.push_back(e);
        ld_q.push_back(m);
        ld_q.push_back(q);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_now("accept_timeout", "in_ready never asserted");
    endtask

    task automatic issue(input logic [15:0] m, input logic [15:0] q,
                         input logic [31:0] prod, input logic err, input int cy);
        push_exp(m, q, prod, err, cy);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_mcand  = m;
        bus.in_mplier = q;
        wait_ready();
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.out_valid) fail_now("result_timeout", "result not returned");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_now("valid_timeout", "out_valid never asserted");
    endtask

    initial begin
        bit saw_valid;
        int rdy_cyc;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",    {63'd0, bus.in_ready},     64'd0);
        check("rst_out_valid",   {63'd0, bus.out_valid},    64'd0);
        check("rst_mul_start",   {63'd0, bus.mul_start},    64'd0);
        check("rst_mul_data",    {48'd0, bus.mul_data},     64'd0);
        check("rst_out_product", {32'd0, bus.out_product},  64'd0);
        check("rst_out_err",     {63'd0, bus.out_err},      64'd0);
        check("rst_out_cycles",  64'(bus.out_cycles),       64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

        // 35 x 30
        issue(16'd35, 16'd30, 32'd1050, 1'b0, 16);
        wait_idle();

        // Signed operands
        issue(16'hFFF9, 16'd5,   32'hFFFFFFDD, 1'b0, 16);
        issue(16'h8000, 16'h8000, 32'h40000000, 1'b0, 16);
        wait_idle();

        // Multiplier never finishes
        done_en = 0;
        issue(16'd1234, 16'd5, 32'd0, 1'b1, 64);
        wait_idle();
        check("in_ready_after_timeout", {63'd0, bus.in_ready}, 64'd1);
        done_en = 1;

        // Consumer stalls in RESP
        bus.out_ready = 1'b0;
        issue(16'd100, 16'hFFFD, 32'hFFFFFED4, 1'b0, 16);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid",   {63'd0, bus.out_valid},   64'd1);
            check("stall_out_product", {32'd0, bus.out_product}, 64'hFFFFFED4);
            check("stall_in_ready",    {63'd0, bus.in_ready},    64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(negedge clk);
        check("post_hs_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("post_hs_in_ready",  {63'd0, bus.in_ready},  64'd1);

        // Reset mid-WAIT, then a late done from the multiplier
        issue(16'd11, 16'd13, 32'd143, 1'b0, 16);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_mul_start", {63'd0, bus.mul_start}, 64'd0);
        check("midrst_mul_data",  {48'd0, bus.mul_data},  64'd0);
        check("midrst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("midrst_product",   {32'd0, bus.out_product}, 64'd0);
        rst = 1'b0;
        saw_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1;
        end
        check("late_done_no_result", {63'd0, saw_valid}, 64'd0);
        issue(16'hFF38, 16'd50, 32'hFFFFD8F0, 1'b0, 16);
        wait_idle();

        // Two queued pairs with in_valid held high
        push_exp(16'd9,   16'hFFF7, 32'hFFFFFFAF, 1'b0, 16);
        push_exp(16'd300, 16'd200,  32'h0000EA60, 1'b0, 16);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_mcand  = 16'd9;
        bus.in_mplier = 16'hFFF7;
        wait_ready();
        @(posedge clk);
        #1;
        bus.in_mcand  = 16'd300;
        bus.in_mplier = 16'd200;
        @(negedge clk);
        wait_ready();
        rdy_cyc = cyc;
        check("second_accept_cycle", 64'(rdy_cyc - hs_cyc), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_idle();

        check("queues_drained", 64'(exp_q.size() + ld_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/booth_operand_sequencer.md
Name: booth_operand_sequencer

Overview:
Upstream front end for the 16-bit Booth multiplier datapath/controller pair. It accepts an operand pair over a valid/ready handshake and serialises it onto the multiplier's shared 16-bit data bus: multiplicand first, multiplier one cycle later. It then waits for the multiplier's done, captures the 2*WIDTH product {A,Q}, and returns it over a valid/ready handshake. A timeout flags a multiplier that never asserts done.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH.
TIMEOUT, 64, maximum cycles spent in WAIT before the error path is taken; must be >= 2.
CNT_W, $clog2(TIMEOUT+1), width of the cycle counter and of out_cycles.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  sequencer can accept an operand pair.
in_mcand  in  WIDTH  multiplicand (M), two's complement.
in_mplier  in  WIDTH  multiplier (Q), two's complement.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_product  out  2*WIDTH  signed product, {A,Q}.
out_err  out  1  result is a timeout (product forced to 0).
out_cycles  out  CNT_W  number of cycles spent in WAIT for this result.
mul_start  out  1  start to the Booth controller.
mul_data  out  WIDTH  shared load bus to the Booth datapath (data_in).
mul_done  in  1  done from the Booth controller.
mul_a  in  WIDTH  datapath A register (product upper half).
mul_q  in  WIDTH  datapath Q register (product lower half).

Behaviour:
- States: IDLE, LOAD_M, LOAD_Q, WAIT, RESP. Reset state is IDLE.
- Reset: in_ready=0 during the reset cycle and 1 in the first cycle after. All other outputs are 0 and the cycle counter is 0. Reset in any state abandons the operation with no result emitted. mul_start is low, so the multiplier idles.
- IDLE:
  - in_ready=1, mul_start=0, mul_data=0.
  - When in_valid&&in_ready, latch in_mcand/in_mplier, clear the counter, go to LOAD_M.
- LOAD_M (1 cycle): mul_start=1, mul_data=latched M. Go to LOAD_Q.
- LOAD_Q (1 cycle): mul_start=1, mul_data=latched Q. Go to WAIT.
- WAIT:
  - mul_start=0, mul_data=0.
  - Counter increments each cycle it remains in WAIT.
  - If mul_done=1: register out_product={mul_a,mul_q}, out_err=0, out_cycles=counter+1. Go to RESP.
  - Else if counter==TIMEOUT-1: out_product=0, out_err=1, out_cycles=TIMEOUT. Go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - out_valid=1; out_product, out_err and out_cycles are held stable.
  - On out_ready: out_valid drops next cycle and the state returns to IDLE.
  - out_ready while out_valid=0 has no effect.
- in_ready is 0 in every state except IDLE, so there is exactly one operation in flight. A new pair is accepted no earlier than the cycle after the RESP handshake.
- mul_done is ignored outside WAIT.
- Latency: accept edge, then 2 load cycles, then N WAIT cycles, then out_valid in the cycle after done is sampled.
- Product is passed through unmodified; the sequencer does not sign-extend or correct it.

Decomposition:
- Shared package booth_pkg:
  - state enum {IDLE, LOAD_M, LOAD_Q, WAIT, RESP};
  - constants BOOTH_WIDTH=16 and BOOTH_TIMEOUT=64.
- One sub-module: booth_seq_timer.
  - Inputs: clear, enable.
  - Outputs: count, expired at TIMEOUT-1.
  - Synchronous and active-high, matching rst.
- The FSM, operand latches and result registers stay in booth_operand_sequencer.

Test Plan:
1. Accept 35 x 30 with a behavioural Booth model (done after 16 cycles). Required response:
   - mul_data=35 then 30 on consecutive cycles, with mul_start high for exactly those 2 cycles;
   - out_product=32'd1050, out_err=0, out_cycles=16.
2. Signed operands -7 x 5 and -32768 x -32768. Required response: out_product=32'hFFFFFFDD and 32'h40000000 respectively.
3. Model never asserts done. Required response: after TIMEOUT WAIT cycles, out_valid=1, out_err=1, out_product=0, out_cycles=64; in_ready returns to 1 after the handshake.
4. out_ready held low for 5 cycles in RESP. Required response: out_valid and out_product stay stable for all 5 cycles; in_ready stays 0; IDLE is entered only after the handshake.
5. rst asserted mid-WAIT. Required response: next cycle state is IDLE with all outputs 0; a late mul_done causes no result; the next operand pair completes correctly.
6. in_valid held high with two queued pairs. Required response: the second pair is accepted only in the cycle after the first RESP handshake; results return in order.
